// File: rtl/shift_tx_sequencer_pkg.sv
// Shared types and constants for the parallel-to-serial transmit sequencer.
// The state enum and direction encodings are used by the RTL and the bench.
package shift_tx_sequencer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic DIR_MSB = 1'b0;
  localparam logic DIR_LSB = 1'b1;

endpackage

// File: rtl/shift_tx_sequencer.sv
// Accepts parallel words over valid/ready, buffers one pending word and
// serialises each word MSB- or LSB-first, with a per-cycle enable for stalling.
module shift_tx_sequencer
  import shift_tx_sequencer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  input  logic             en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t state, next_state;

  logic [WIDTH-1:0] shift_data;
  logic             shift_dir;
  logic [CNT_W-1:0] shift_cnt;
  logic [WIDTH-1:0] pend_data;
  logic             pend_dir;
  logic             pend_full;

  logic             accept;
  logic             at_last;
  logic             load_in;
  logic             load_pend;
  logic             advance;
  logic             to_pend;
  logic [CNT_W-1:0] head_idx;

  assign in_ready = !pend_full;
  assign accept   = in_valid && in_ready;
  assign at_last  = (state == SHIFT) && (shift_cnt == LAST_CNT);

  // Head bit walks upward for LSB-first words and downward for MSB-first ones.
  assign head_idx  = (shift_dir == DIR_LSB) ? shift_cnt : (LAST_CNT - shift_cnt);
  assign ser_out   = (state == SHIFT) && shift_data[head_idx];
  assign ser_valid = (state == SHIFT);
  assign ser_last  = at_last;
  assign busy      = (state == SHIFT) || pend_full;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // On a consumed last bit the pending word has priority over a fresh one;
  // in that case in_ready was low, so the two never compete on one edge.
  always_comb begin
    next_state = state;
    load_in    = 1'b0;
    load_pend  = 1'b0;
    advance    = 1'b0;
    to_pend    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          load_in    = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (en && at_last) begin
          if (pend_full) begin
            load_pend = 1'b1;
          end else if (accept) begin
            load_in = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end else begin
          advance = en;
          to_pend = accept;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      shift_data <= '0;
      shift_dir  <= DIR_MSB;
      shift_cnt  <= '0;
      pend_data  <= '0;
      pend_dir   <= DIR_MSB;
      pend_full  <= 1'b0;
    end else begin
      if (load_in) begin
        shift_data <= in_data;
        shift_dir  <= in_dir;
        shift_cnt  <= '0;
      end else if (load_pend) begin
        shift_data <= pend_data;
        shift_dir  <= pend_dir;
        shift_cnt  <= '0;
      end else if (advance) begin
        shift_cnt  <= shift_cnt + 1'b1;
      end

      if (load_pend) begin
        pend_full <= 1'b0;
      end else if (to_pend) begin
        pend_data <= in_data;
        pend_dir  <= in_dir;
        pend_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shift_tx_sequencer.sv
// Directed self-checking bench for shift_tx_sequencer (WIDTH=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_shift_tx_sequencer;

  logic       clk;
  logic       clr;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_dir;
  logic       en;
  logic       ser_out;
  logic       ser_valid;
  logic       ser_last;
  logic       busy;

  int compared;
  int mismatched;

  shift_tx_sequencer #(.WIDTH(4)) dut (
    .clk       (clk),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dir    (in_dir),
    .en        (en),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .ser_last  (ser_last),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    @(negedge clk);
    compared++; if (ser_out !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ser_out: got %b want 0", ser_out); end
    compared++; if (ser_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ser_valid: got %b want 0", ser_valid); end
    compared++; if (ser_last !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ser_last: got %b want 0", ser_last); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    clr = 1'b0;
  endtask

  task automatic test_single(input logic [3:0] word, input logic dir, input logic [3:0] seq, input string tag);
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL %s_ready0: got %b want 1", tag, in_ready); end
    in_valid = 1'b1; in_data = word; in_dir = dir; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin in_valid = 1'b0; in_dir = ~dir; end
      compared++; if (ser_out !== seq[3-i]) begin mismatched++; $display("[TB] FAIL %s_bit%0d: got %b want %b", tag, i, ser_out, seq[3-i]); end
      compared++; if (ser_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL %s_valid%0d: got %b want 1", tag, i, ser_valid); end
      compared++; if (ser_last !== (i == 3)) begin mismatched++; $display("[TB] FAIL %s_last%0d: got %b want %b", tag, i, ser_last, (i == 3)); end
    end
    @(negedge clk);
    compared++; if (ser_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL %s_end_valid: got %b want 0", tag, ser_valid); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL %s_end_busy: got %b want 0", tag, busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq;
    logic [7:0] rdy;
    seq = 8'b1100_0011;
    rdy = 8'b1000_1111;
    in_valid = 1'b1; in_data = 4'b1100; in_dir = 1'b0; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) in_data = 4'b0011;
      if (i == 1) in_valid = 1'b0;
      compared++; if (ser_out !== seq[7-i]) begin mismatched++; $display("[TB] FAIL b2b_bit%0d: got %b want %b", i, ser_out, seq[7-i]); end
      compared++; if (ser_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_valid%0d: got %b want 1", i, ser_valid); end
      compared++; if (ser_last !== (i == 3 || i == 7)) begin mismatched++; $display("[TB] FAIL b2b_last%0d: got %b want %b", i, ser_last, (i == 3 || i == 7)); end
      compared++; if (in_ready !== rdy[7-i]) begin mismatched++; $display("[TB] FAIL b2b_ready%0d: got %b want %b", i, in_ready, rdy[7-i]); end
    end
    @(negedge clk);
    compared++; if (ser_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_end_valid: got %b want 0", ser_valid); end
  endtask

  task automatic test_stall();
    logic [6:0] seq;
    logic [6:0] en_tab;
    int valid_cycles;
    seq = 7'b1000010;
    en_tab = 7'b1000111;
    valid_cycles = 0;
    in_valid = 1'b1; in_data = 4'b1010; in_dir = 1'b0; en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (ser_valid === 1'b1) valid_cycles++;
      compared++; if (ser_out !== seq[6-i]) begin mismatched++; $display("[TB] FAIL stall_bit%0d: got %b want %b", i, ser_out, seq[6-i]); end
      compared++; if (ser_last !== (i == 6)) begin mismatched++; $display("[TB] FAIL stall_last%0d: got %b want %b", i, ser_last, (i == 6)); end
      en = en_tab[6-i];
    end
    @(negedge clk);
    if (ser_valid === 1'b1) valid_cycles++;
    compared++; if (valid_cycles !== 7) begin mismatched++; $display("[TB] FAIL stall_valid_cycles: got %0d want 7", valid_cycles); end
    en = 1'b1;
  endtask

  task automatic test_reset_mid_word();
    in_valid = 1'b1; in_data = 4'b1111; in_dir = 1'b0; en = 1'b1;
    @(negedge clk);
    in_data = 4'b0101;
    @(negedge clk);
    in_valid = 1'b0;
    compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_mid_busy_before: got %b want 1", busy); end
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_mid_ready_before: got %b want 0", in_ready); end
    @(negedge clk);
    compared++; if (ser_out !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_mid_bit2: got %b want 1", ser_out); end
    #2 clr = 1'b1;
    #1;
    compared++; if (ser_out !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_mid_ser_out: got %b want 0", ser_out); end
    compared++; if (ser_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_mid_ser_valid: got %b want 0", ser_valid); end
    compared++; if (ser_last !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_mid_ser_last: got %b want 0", ser_last); end
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_mid_in_ready: got %b want 1", in_ready); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_mid_busy: got %b want 0", busy); end
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      compared++; if (ser_valid !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_mid_after%0d: got valid=%b busy=%b want 0/0", i, ser_valid, busy); end
    end
  endtask

  task automatic test_last_full_collision();
    logic [11:0] seq;
    logic [7:0]  rdy;
    seq = 12'b1000_0110_1101;
    rdy = 8'b1000_1000;
    in_valid = 1'b1; in_data = 4'b1000; in_dir = 1'b0; en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) in_data = 4'b0110;
      if (i == 1) in_data = 4'b1101;
      if (i == 5) in_valid = 1'b0;
      compared++; if (ser_out !== seq[11-i]) begin mismatched++; $display("[TB] FAIL coll_bit%0d: got %b want %b", i, ser_out, seq[11-i]); end
      compared++; if (ser_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL coll_valid%0d: got %b want 1", i, ser_valid); end
      compared++; if (ser_last !== (i % 4 == 3)) begin mismatched++; $display("[TB] FAIL coll_last%0d: got %b want %b", i, ser_last, (i % 4 == 3)); end
      if (i < 8) begin
        compared++; if (in_ready !== rdy[7-i]) begin mismatched++; $display("[TB] FAIL coll_ready%0d: got %b want %b", i, in_ready, rdy[7-i]); end
      end
    end
    @(negedge clk);
    compared++; if (ser_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL coll_end_valid: got %b want 0", ser_valid); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL coll_end_busy: got %b want 0", busy); end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    clr      = 1'b1;
    in_valid = 1'b0;
    in_data  = 4'b0000;
    in_dir   = 1'b0;
    en       = 1'b1;
    test_reset();
    test_single(4'b1011, 1'b0, 4'b1011, "msb");
    test_single(4'b1011, 1'b1, 4'b1101, "lsb");
    test_back_to_back();
    test_stall();
    test_reset_mid_word();
    test_last_full_collision();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
